// File: rtl/servo_ui_pkg.sv
// ----------------------------------------------------------------------------
// servo_ui_pkg
//   Shared types and constants for the servo pulse-width operator stage.
//   - stepper_state_t : key-handling FSM states
//   - width_cmd_t     : per-cycle width command decoded from the FSM
//   - WIDTH_W, ABS_*  : pulse-width register width and default bounds (us)
//   - apply_width_cmd : saturating step / recentre arithmetic
// ----------------------------------------------------------------------------
package servo_ui_pkg;

  localparam int unsigned WIDTH_W     = 16;
  localparam int unsigned ABS_MIN     = 500;
  localparam int unsigned ABS_MAX     = 2500;
  localparam int unsigned ABS_DEFAULT = 1500;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD_WAIT = 2'd1,
    REPEAT    = 2'd2,
    LOCKED    = 2'd3
  } stepper_state_t;

  typedef enum logic [1:0] {
    CMD_NONE   = 2'd0,
    CMD_UP     = 2'd1,
    CMD_DOWN   = 2'd2,
    CMD_CENTRE = 2'd3
  } width_cmd_t;

  // One extra bit of headroom so width+step can never wrap before the
  // comparison against the upper bound.
  function automatic logic [WIDTH_W-1:0] apply_width_cmd(
    input logic [WIDTH_W-1:0] width,
    input width_cmd_t         cmd,
    input logic [WIDTH_W-1:0] lo,
    input logic [WIDTH_W-1:0] hi,
    input logic [WIDTH_W-1:0] centre,
    input logic [WIDTH_W-1:0] step
  );
    logic [WIDTH_W:0] up_sum;
    logic [WIDTH_W:0] down_floor;
    logic [WIDTH_W-1:0] result;
    up_sum     = {1'b0, width} + {1'b0, step};
    down_floor = {1'b0, lo} + {1'b0, step};
    case (cmd)
      CMD_UP:     result = (up_sum > {1'b0, hi}) ? hi : up_sum[WIDTH_W-1:0];
      CMD_DOWN:   result = ({1'b0, width} < down_floor) ? lo : (width - step);
      CMD_CENTRE: result = centre;
      default:    result = width;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// ----------------------------------------------------------------------------
// button_debouncer
//   Conditions one raw, asynchronous, active-low push-button: 2-FF
//   synchronizer, inversion to active-high, then a stable-level counter.
//   The debounced level flips only after the synchronized level has
//   disagreed with it for DEBOUNCE_CYCLES+1 consecutive cycles; any cycle of
//   agreement clears the counter, so bounces shorter than that are ignored.
//
//   Ports
//     clk     : system clock
//     reset   : synchronous, active-high; synchronizer and output -> released
//     key_n   : raw active-low key
//     pressed : debounced, active-high key level
// ----------------------------------------------------------------------------
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pressed
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             r_meta;
  logic             r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pressed;

  logic w_level;
  logic w_differs;

  assign w_level   = ~r_sync;
  assign w_differs = (w_level != r_pressed);

  // NOTE: all state here is updated with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours; a blocking '=' would
  // collapse the two synchronizer stages into one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta    <= 1'b1;
      r_sync    <= 1'b1;
      r_cnt     <= '0;
      r_pressed <= 1'b0;
    end else begin
      r_meta <= key_n;
      r_sync <= r_meta;
      if (w_differs) begin
        if (r_cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
          r_pressed <= w_level;
          r_cnt     <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign pressed = r_pressed;

endmodule

// File: rtl/servo_width_stepper.sv
// ----------------------------------------------------------------------------
// servo_width_stepper
//   Turns two raw push-buttons into a saturating 16-bit servo pulse width in
//   microseconds. Single press = one step, hold = auto-repeat after an
//   initial delay, both keys together = recentre to DEFAULT_WIDTH and lock
//   out stepping until both keys are released.
//
//   Ports
//     clk           : system clock (50 MHz)
//     reset         : synchronous, active-high
//     key_up_n      : raw active-low up key
//     key_down_n    : raw active-low down key
//     width_out     : current pulse width (us), MIN_WIDTH..MAX_WIDTH
//     width_changed : one-cycle pulse on the cycle width_out takes a new value
//     tick          : one-cycle display refresh strobe, free-running, also
//                     forced the cycle after width_changed
//     at_min        : width_out == MIN_WIDTH
//     at_max        : width_out == MAX_WIDTH
// ----------------------------------------------------------------------------
module servo_width_stepper
  import servo_ui_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000,
  parameter int unsigned TICK_CYCLES     = 5000000,
  parameter int unsigned MIN_WIDTH       = ABS_MIN,
  parameter int unsigned MAX_WIDTH       = ABS_MAX,
  parameter int unsigned DEFAULT_WIDTH   = ABS_DEFAULT,
  parameter int unsigned STEP            = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_up_n,
  input  logic               key_down_n,
  output logic [WIDTH_W-1:0] width_out,
  output logic               width_changed,
  output logic               tick,
  output logic               at_min,
  output logic               at_max
);

  // --------------------------------------------------------------------------
  // Parameter legality
  // --------------------------------------------------------------------------
  if (!(MIN_WIDTH <= DEFAULT_WIDTH && DEFAULT_WIDTH <= MAX_WIDTH &&
        MAX_WIDTH <= 9999 && STEP >= 1 && STEP <= 9999 &&
        DEBOUNCE_CYCLES >= 1 && HOLD_CYCLES >= 1 &&
        REPEAT_CYCLES >= 1 && TICK_CYCLES >= 1)) begin : g_bad_params
    $error("servo_width_stepper: illegal parameter combination");
  end

  localparam int unsigned DELAY_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                                      HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CNT_W  = $clog2(DELAY_MAX + 1);
  localparam int unsigned TICK_W = $clog2(TICK_CYCLES + 1);

  localparam logic [WIDTH_W-1:0] MIN_W     = WIDTH_W'(MIN_WIDTH);
  localparam logic [WIDTH_W-1:0] MAX_W     = WIDTH_W'(MAX_WIDTH);
  localparam logic [WIDTH_W-1:0] DEFAULT_W = WIDTH_W'(DEFAULT_WIDTH);
  localparam logic [WIDTH_W-1:0] STEP_W    = WIDTH_W'(STEP);
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic w_up;
  logic w_down;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk     (clk),
    .reset   (reset),
    .key_n   (key_up_n),
    .pressed (w_up)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .clk     (clk),
    .reset   (reset),
    .key_n   (key_down_n),
    .pressed (w_down)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  stepper_state_t     r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_dir_up;       // which key started the current hold
  logic [WIDTH_W-1:0] r_width;
  logic               r_width_changed;
  logic               r_at_min;
  logic               r_at_max;
  logic [TICK_W-1:0]  r_tick_cnt;
  logic               r_tick;

  logic               w_both;
  logic               w_dir_held;
  width_cmd_t         w_dir_cmd;
  width_cmd_t         w_cmd;
  logic [WIDTH_W-1:0] w_cmd_width;

  assign w_both     = w_up & w_down;
  assign w_dir_held = r_dir_up ? w_up : w_down;
  assign w_dir_cmd  = r_dir_up ? CMD_UP : CMD_DOWN;

  // Width command for this cycle. The FSM below uses the same conditions for
  // its transitions; keeping the decode here lets the width register and its
  // flags update on the very edge the step is decided.
  // NOTE: w_cmd gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_cmd = CMD_NONE;
    case (r_state)
      IDLE: begin
        if (w_both)      w_cmd = CMD_CENTRE;
        else if (w_up)   w_cmd = CMD_UP;
        else if (w_down) w_cmd = CMD_DOWN;
      end
      HOLD_WAIT: begin
        if (w_both)                              w_cmd = CMD_CENTRE;
        else if (w_dir_held && r_cnt == HOLD_LAST) w_cmd = w_dir_cmd;
      end
      REPEAT: begin
        if (w_both)                             w_cmd = CMD_CENTRE;
        else if (w_dir_held && r_cnt == REP_LAST) w_cmd = w_dir_cmd;
      end
      default: w_cmd = CMD_NONE;
    endcase
  end

  assign w_cmd_width = apply_width_cmd(r_width, w_cmd, MIN_W, MAX_W,
                                       DEFAULT_W, STEP_W);

  // --------------------------------------------------------------------------
  // Key FSM and width register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_dir_up        <= 1'b0;
      r_width         <= DEFAULT_W;
      r_width_changed <= 1'b0;
      r_at_min        <= (DEFAULT_W == MIN_W);
      r_at_max        <= (DEFAULT_W == MAX_W);
    end else begin
      // Width and its flags move together so at_min/at_max never lag.
      if (w_cmd != CMD_NONE) begin
        r_width         <= w_cmd_width;
        r_width_changed <= (w_cmd_width != r_width);
        r_at_min        <= (w_cmd_width == MIN_W);
        r_at_max        <= (w_cmd_width == MAX_W);
      end else begin
        r_width_changed <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_both) begin
            r_state <= LOCKED;
          end else if (w_up || w_down) begin
            r_dir_up <= w_up;
            r_state  <= HOLD_WAIT;
          end
        end
        HOLD_WAIT: begin
          if (w_both) begin
            r_state <= LOCKED;
          end else if (!w_dir_held) begin
            r_state <= IDLE;
          end else if (r_cnt == HOLD_LAST) begin
            r_cnt   <= '0;
            r_state <= REPEAT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (w_both) begin
            r_state <= LOCKED;
          end else if (!w_dir_held) begin
            r_state <= IDLE;
          end else if (r_cnt == REP_LAST) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        LOCKED: begin
          r_cnt <= '0;
          if (!w_up && !w_down) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Display refresh tick
  // --------------------------------------------------------------------------
  // A forced tick is suppressed if a tick is already on the line this cycle
  // (the display already sees the new width), and then the free-running count
  // is left alone. Whatever fires, tick is never high two cycles running.
  logic w_tick_force;
  logic w_tick_natural;
  logic w_tick_restart;

  assign w_tick_force   = r_width_changed & ~r_tick;
  assign w_tick_natural = (r_tick_cnt == TICK_LAST);
  assign w_tick_restart = w_tick_force | w_tick_natural;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_tick     <= w_tick_restart & ~r_tick;
      r_tick_cnt <= w_tick_restart ? '0 : (r_tick_cnt + TICK_W'(1));
    end
  end

  assign width_out     = r_width;
  assign width_changed = r_width_changed;
  assign tick          = r_tick;
  assign at_min        = r_at_min;
  assign at_max        = r_at_max;

endmodule
